// File: rtl/titan_pkg.sv
// Shared types for the Titan instruction prefetcher: FSM state encoding and the
// 66-bit queue entry layout {pc[65:34], inst[33:2], fault[1], misalign[0]}.
package titan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } pf_state_t;

    localparam int ENTRY_W   = 66;
    localparam int MIS_BIT   = 0;
    localparam int FAULT_BIT = 1;
    localparam int INST_LSB  = 2;
    localparam int PC_LSB    = 34;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
        logic        misalign;
    } pf_entry_t;

    function automatic pf_entry_t make_entry(input logic [31:0] pc,
                                             input logic [31:0] inst,
                                             input logic        fault,
                                             input logic        misalign);
        pf_entry_t e;
        e.pc       = pc;
        e.inst     = inst;
        e.fault    = fault;
        e.misalign = misalign;
        return e;
    endfunction

endpackage

// File: rtl/titan_sync_fifo.sv
// Synchronous queue for prefetched entries. Head is read straight from the
// storage array through a mux on rd_ptr, so no extra read latency. A clear
// empties the queue; a push in the same cycle lands as the sole new entry.
module titan_sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 66,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_sel;
    logic          do_pop;

    assign do_pop = pop && (count != '0) && !clear;
    assign wr_sel = clear ? '0 : wr_ptr;
    assign rdata  = mem[rd_ptr];

    // Entry storage; no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_sel] <= wdata;
    end

    // Pointer and occupancy bookkeeping; clear wins over a same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= push ? AW'(1) : '0;
            count  <= push ? CW'(1) : '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/titan_prefetch_unit.sv
// Titan instruction prefetcher: fetches sequential words over Wishbone into a
// DEPTH-entry queue, handles redirects, and records bus/misalign faults.
// Optional feature macro: TITAN_PREFETCH_BYPASS_EN (same-cycle presentation of
// an acked word when the queue is empty).
module titan_prefetch_unit
    import titan_pkg::*;
#(
    parameter  logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter  int          DEPTH      = 4,
    localparam int          CW         = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    output logic          inst_valid_o,
    input  logic          inst_ready_i,
    output logic [31:0]   inst_o,
    output logic [31:0]   inst_pc_o,
    output logic          inst_fault_o,
    output logic          inst_misalign_o,
    output logic [CW-1:0] count_o,
    output logic [31:0]   iwbm_addr_o,
    output logic          iwbm_cyc_o,
    output logic          iwbm_stb_o,
    input  logic [31:0]   iwbm_dat_i,
    input  logic          iwbm_ack_i,
    input  logic          iwbm_err_i
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    pf_state_t     state;
    logic [31:0]   fetch_pc;
    logic [31:0]   addr_q;
    logic          bus_q;
    pf_entry_t     head;
    pf_entry_t     wentry;
    logic          push;
    logic          pop;
    logic          bypass;
    logic [CW-1:0] count;
    logic [CW-1:0] cnt_next;
    logic          bus_done;
    logic          redirect_mis;

    assign bus_done     = iwbm_ack_i || iwbm_err_i;
    assign redirect_mis = (redirect_pc_i[1:0] != 2'b00);
    assign pop          = (count != '0) && inst_ready_i && !redirect_i;
    assign cnt_next     = count + CW'(push) - CW'(pop);

    titan_sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(pf_entry_t))
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .clear (redirect_i),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    // Decide what (if anything) enters the queue this cycle.
    always_comb begin
        push   = 1'b0;
        wentry = '0;
        bypass = 1'b0;
`ifdef TITAN_PREFETCH_BYPASS_EN
        bypass = (count == '0) && (state == ST_REQ) && iwbm_ack_i && !iwbm_err_i && !redirect_i;
`endif
        if (redirect_i) begin
            if (redirect_mis) begin
                push   = 1'b1;
                wentry = make_entry(redirect_pc_i, 32'h0, 1'b0, 1'b1);
            end
        end else if (state == ST_REQ) begin
            if (iwbm_err_i) begin
                push   = 1'b1;
                wentry = make_entry(fetch_pc, 32'h0, 1'b1, 1'b0);
            end else if (iwbm_ack_i) begin
                // A bypassed word already consumed by IF never needs storing.
                push   = !(bypass && inst_ready_i);
                wentry = make_entry(fetch_pc, iwbm_dat_i, 1'b0, 1'b0);
            end
        end
    end

    // Head presentation to IF; fields read as zero while the queue is empty.
    always_comb begin
        inst_valid_o    = (count != '0);
        inst_o          = inst_valid_o ? head.inst : 32'h0;
        inst_pc_o       = inst_valid_o ? head.pc : 32'h0;
        inst_fault_o    = inst_valid_o && head.fault;
        inst_misalign_o = inst_valid_o && head.misalign;
        if (bypass) begin
            inst_valid_o    = 1'b1;
            inst_o          = iwbm_dat_i;
            inst_pc_o       = fetch_pc;
            inst_fault_o    = 1'b0;
            inst_misalign_o = 1'b0;
        end
    end

    // Fetch FSM with registered Wishbone drive; redirect overrides every state.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_ADDR;
            addr_q   <= RESET_ADDR;
            bus_q    <= 1'b0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            if (redirect_mis) begin
                state <= ST_HALT;
                bus_q <= 1'b0;
            end else if ((state == ST_REQ || state == ST_DRAIN) && !bus_done) begin
                // Outstanding cycle must complete on the old address first.
                state <= ST_DRAIN;
            end else begin
                state  <= ST_REQ;
                bus_q  <= 1'b1;
                addr_q <= redirect_pc_i;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count < FULL) begin
                        state  <= ST_REQ;
                        bus_q  <= 1'b1;
                        addr_q <= fetch_pc;
                    end
                end
                ST_REQ: begin
                    if (iwbm_err_i) begin
                        state <= ST_HALT;
                        bus_q <= 1'b0;
                    end else if (iwbm_ack_i) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (cnt_next < FULL) begin
                            addr_q <= fetch_pc + 32'd4;
                        end else begin
                            state <= ST_IDLE;
                            bus_q <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus_done) begin
                        state  <= ST_REQ;
                        addr_q <= fetch_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign iwbm_addr_o = addr_q;
    assign iwbm_cyc_o  = bus_q;
    assign iwbm_stb_o  = bus_q;
    assign count_o     = count;

    a_no_ack_when_full : assert property (@(posedge clk_i) disable iff (!rst_i)
        !(state == ST_REQ && iwbm_ack_i && count == FULL));

endmodule

// File: tb/tb_titan_prefetch_unit.sv
// Directed self-checking bench for titan_prefetch_unit (DEPTH=4).
// Bus slave: ack/err are gated combinationally by stb; data = addr ^ 32'hA5A5_0000.
module tb_titan_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;
    logic        inst_misalign_o;
    logic [2:0]  count_o;
    logic [31:0] iwbm_addr_o;
    logic        iwbm_cyc_o;
    logic        iwbm_stb_o;
    logic [31:0] iwbm_dat_i;
    logic        iwbm_ack_i;
    logic        iwbm_err_i;
    logic        ack_en;
    logic        err_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign iwbm_ack_i = iwbm_stb_o && ack_en;
    assign iwbm_err_i = iwbm_stb_o && err_en;
    assign iwbm_dat_i = iwbm_addr_o ^ 32'hA5A5_0000;

    titan_prefetch_unit #(
        .RESET_ADDR (32'h0000_0000),
        .DEPTH      (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_fault_o    (inst_fault_o),
        .inst_misalign_o (inst_misalign_o),
        .count_o         (count_o),
        .iwbm_addr_o     (iwbm_addr_o),
        .iwbm_cyc_o      (iwbm_cyc_o),
        .iwbm_stb_o      (iwbm_stb_o),
        .iwbm_dat_i      (iwbm_dat_i),
        .iwbm_ack_i      (iwbm_ack_i),
        .iwbm_err_i      (iwbm_err_i)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        inst_ready_i  = 1'b0;
        ack_en        = 1'b0;
        err_en        = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        int maxrun;

        // 1: reset state, then back-to-back fill to DEPTH with IF stalled
        reset_dut();
        expect_eq("rst_valid", 32'(inst_valid_o), 32'd0);
        expect_eq("rst_stb", 32'(iwbm_stb_o), 32'd0);
        expect_eq("rst_cyc", 32'(iwbm_cyc_o), 32'd0);
        expect_eq("rst_count", 32'(count_o), 32'd0);
        expect_eq("rst_addr", iwbm_addr_o, 32'h0);
        expect_eq("rst_inst", inst_o, 32'h0);
        rst_i  = 1'b1;
        ack_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_eq("fill_stb", 32'(iwbm_stb_o), 32'd1);
            expect_eq("fill_addr", iwbm_addr_o, 32'(4 * i));
        end
        step();
        expect_eq("full_count", 32'(count_o), 32'd4);
        expect_eq("full_stb", 32'(iwbm_stb_o), 32'd0);
        expect_eq("full_head_pc", inst_pc_o, 32'h0);
        expect_eq("full_head_inst", inst_o, 32'hA5A5_0000);
        step();
        expect_eq("full_hold_count", 32'(count_o), 32'd4);
        expect_eq("full_hold_stb", 32'(iwbm_stb_o), 32'd0);

        // 2: IF ready continuously, one entry per cycle
        inst_ready_i = 1'b1;
        step();
        expect_eq("drain_count", 32'(count_o), 32'd3);
        expect_eq("drain_pc", inst_pc_o, 32'h4);
        run    = 0;
        maxrun = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_eq("stream_valid", 32'(inst_valid_o), 32'd1);
            expect_eq("stream_pc", inst_pc_o, 32'(8 + 4 * i));
            if (!iwbm_stb_o) run++;
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
        expect_eq("stream_stb_gap_ok", 32'(maxrun <= 1), 32'd1);

        // 3: redirect while REQ at 0x8 with a delayed ack
        reset_dut();
        rst_i  = 1'b1;
        ack_en = 1'b1;
        step();
        step();
        step();
        expect_eq("pre_redir_addr", iwbm_addr_o, 32'h8);
        ack_en        = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        expect_eq("redir_count", 32'(count_o), 32'd0);
        expect_eq("redir_valid", 32'(inst_valid_o), 32'd0);
        expect_eq("drain_stb", 32'(iwbm_stb_o), 32'd1);
        expect_eq("drain_addr", iwbm_addr_o, 32'h8);
        step();
        step();
        expect_eq("drain_hold_addr", iwbm_addr_o, 32'h8);
        ack_en = 1'b1;
        step();
        expect_eq("after_drain_addr", iwbm_addr_o, 32'h100);
        expect_eq("after_drain_stb", 32'(iwbm_stb_o), 32'd1);
        expect_eq("drain_discard_count", 32'(count_o), 32'd0);
        step();
        expect_eq("redir_first_count", 32'(count_o), 32'd1);
        expect_eq("redir_first_pc", inst_pc_o, 32'h100);
        expect_eq("redir_first_inst", inst_o, 32'hA5A5_0100);

        // 4: bus error on the fetch at 0x40
        reset_dut();
        rst_i         = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        ack_en        = 1'b1;
        err_en        = 1'b1;
        step();
        redirect_i = 1'b0;
        expect_eq("err_req_addr", iwbm_addr_o, 32'h40);
        expect_eq("err_req_stb", 32'(iwbm_stb_o), 32'd1);
        step();
        expect_eq("err_count", 32'(count_o), 32'd1);
        expect_eq("err_pc", inst_pc_o, 32'h40);
        expect_eq("err_fault", 32'(inst_fault_o), 32'd1);
        expect_eq("err_inst", inst_o, 32'h0);
        expect_eq("err_stb", 32'(iwbm_stb_o), 32'd0);
        step();
        step();
        step();
        expect_eq("halt_stb", 32'(iwbm_stb_o), 32'd0);
        err_en        = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        step();
        redirect_i = 1'b0;
        expect_eq("resume_addr", iwbm_addr_o, 32'h80);
        expect_eq("resume_stb", 32'(iwbm_stb_o), 32'd1);
        expect_eq("resume_count", 32'(count_o), 32'd0);
        step();
        expect_eq("resume_pc", inst_pc_o, 32'h80);
        expect_eq("resume_fault", 32'(inst_fault_o), 32'd0);

        // 5: misaligned redirect
        ack_en        = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        step();
        redirect_i = 1'b0;
        expect_eq("mis_count", 32'(count_o), 32'd1);
        expect_eq("mis_pc", inst_pc_o, 32'h102);
        expect_eq("mis_flag", 32'(inst_misalign_o), 32'd1);
        expect_eq("mis_fault", 32'(inst_fault_o), 32'd0);
        expect_eq("mis_inst", inst_o, 32'h0);
        expect_eq("mis_cyc", 32'(iwbm_cyc_o), 32'd0);
        step();
        step();
        step();
        expect_eq("mis_halt_stb", 32'(iwbm_stb_o), 32'd0);
        expect_eq("mis_halt_count", 32'(count_o), 32'd1);

        // 6: ack -> valid latency with an empty queue and IF ready
        reset_dut();
        rst_i         = 1'b1;
        inst_ready_i  = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        expect_eq("lat_addr", iwbm_addr_o, 32'h200);
        ack_en = 1'b1;
        #1;
`ifdef TITAN_PREFETCH_BYPASS_EN
        expect_eq("byp_valid", 32'(inst_valid_o), 32'd1);
        expect_eq("byp_inst", inst_o, 32'hA5A5_0200);
        expect_eq("byp_pc", inst_pc_o, 32'h200);
        step();
        ack_en = 1'b0;
        #1;
        expect_eq("byp_count", 32'(count_o), 32'd0);
        expect_eq("byp_next_addr", iwbm_addr_o, 32'h204);
`else
        expect_eq("lat_valid_ack_cycle", 32'(inst_valid_o), 32'd0);
        step();
        ack_en = 1'b0;
        #1;
        expect_eq("lat_valid_next", 32'(inst_valid_o), 32'd1);
        expect_eq("lat_count", 32'(count_o), 32'd1);
        expect_eq("lat_pc", inst_pc_o, 32'h200);
        expect_eq("lat_inst", inst_o, 32'hA5A5_0200);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
